// File: rtl/intirvx_ifetch_pf_pkg.sv
// Shared types, constants and helpers for the intirvx instruction-fetch front end.
// Build option INTIRVX_IFETCH_ERR_EN adds an error flag to every buffered entry.
package intirvx_ifetch_pf_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;
  localparam int ILEN = 4;

  localparam int              IFETCH_PAGE_BYTES = 4096;
  localparam logic [ALEN-1:0] IFETCH_INCR       = 32'd4;

  localparam logic [2:0] AXI_SIZE_S32   = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } ifetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [ALEN-1:0] pc;
`ifdef INTIRVX_IFETCH_ERR_EN
    logic            err;
`endif
  } ifetch_entry_t;

  // Words left before the next 4 KB boundary, capped at the configured burst length.
  function automatic logic [12:0] ifetch_beats(input logic [11:0] offset,
                                               input logic [12:0] max_beats);
    logic [12:0] room;
    room = (13'(IFETCH_PAGE_BYTES) - {1'b0, offset}) >> 2;
    if (room > max_beats) begin
      return max_beats;
    end else begin
      return room;
    end
  endfunction

endpackage

// File: rtl/intirvx_ifetch_pf_buf.sv
// Circular instruction buffer with flush and an occupancy count for credit accounting.
// Entry layout follows ifetch_entry_t (INTIRVX_IFETCH_ERR_EN widens it by one bit).
module intirvx_ifetch_buf
  import intirvx_ifetch_pf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int EW    = $bits(ifetch_entry_t)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [EW-1:0] enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [EW-1:0] deq_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          enq_fire_s;
  logic          deq_fire_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Handshake decode; a full buffer still accepts when the head leaves the same cycle.
  always_comb begin
    full_s     = (count_r == CW'(DEPTH));
    deq_valid  = (count_r != {CW{1'b0}});
    enq_ready  = !full_s || deq_ready;
    deq_fire_s = deq_valid && deq_ready && !flush;
    enq_fire_s = enq_valid && enq_ready && !flush;
    deq_data   = mem_r[rd_ptr_r];
    count      = count_r;
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (enq_fire_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (deq_fire_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      mem_r[wr_ptr_r] <= enq_data;
    end
  end

endmodule

// File: rtl/intirvx_ifetch_pf.sv
// Instruction-fetch front end: credit-gated AXI INCR read bursts into a decode-side buffer.
// Build option INTIRVX_IFETCH_ERR_EN adds inst_err and stops fetching on a bad response.
module intirvx_ifetch_pf
  import intirvx_ifetch_pf_pkg::*;
#(
  parameter int BURST_LEN    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int SEQ_PREFETCH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ILEN-1:0] hart_id,
  output logic            ar_valid,
  input  logic            ar_ready,
  output logic [ALEN-1:0] ar_addr,
  output logic [7:0]      ar_len,
  output logic [2:0]      ar_size,
  output logic [1:0]      ar_burst,
  output logic [2:0]      ar_prot,
  output logic [ILEN-1:0] ar_id,
  input  logic            r_valid,
  output logic            r_ready,
  input  logic [XLEN-1:0] r_data,
  input  logic [1:0]      r_resp,
  input  logic            r_last,
  output logic            aw_valid,
  output logic            w_valid,
  output logic            b_ready,
  output logic [XLEN-1:0] inst,
  output logic [ALEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
`ifdef INTIRVX_IFETCH_ERR_EN
  output logic            inst_err,
`endif
  input  logic [XLEN-1:0] target,
  input  logic            target_valid,
  output logic            target_ready,
  input  logic            flush
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(BURST_LEN + 1);
  localparam int EW = $bits(ifetch_entry_t);

  ifetch_state_t   state_r;
  logic            ar_valid_r;
  logic [ALEN-1:0] ar_addr_r;
  logic [7:0]      ar_len_r;
  logic [ILEN-1:0] ar_id_r;
  logic            r_ready_r;
  logic [IW-1:0]   inflight_r;
  logic [ALEN-1:0] pc_r;
  logic [ALEN-1:0] next_pc_r;
  logic            pf_armed_r;
  logic            flush_seen_r;

  logic [ALEN-1:0] tgt_addr_s;
  logic [12:0]     beats_tgt_s;
  logic [12:0]     beats_pf_s;
  logic [12:0]     free_s;
  logic            take_tgt_s;
  logic            take_pf_s;
  logic [ALEN-1:0] issue_addr_s;
  logic [12:0]     issue_beats_s;
  logic            beat_s;
  logic            beat_err_s;
  logic            enq_valid_s;
  ifetch_entry_t   enq_entry_s;
  ifetch_entry_t   head_s;
  logic [EW-1:0]   head_bits_s;
  logic [CW-1:0]   count_s;
  logic            enq_ready_unused_s;
  logic            unused_s;

`ifdef INTIRVX_IFETCH_ERR_EN
  assign beat_err_s = (r_resp != AXI_RESP_OKAY);
  assign unused_s   = ^target[1:0];
`else
  assign beat_err_s = 1'b0;
  assign unused_s   = ^{target[1:0], r_resp};
`endif

  // Issue decision: credits cover the whole burst, and a redirect outranks the prefetch.
  always_comb begin
    tgt_addr_s    = {target[XLEN-1:2], 2'b00};
    beats_tgt_s   = ifetch_beats(tgt_addr_s[11:0], 13'(BURST_LEN));
    beats_pf_s    = ifetch_beats(next_pc_r[11:0], 13'(BURST_LEN));
    free_s        = 13'(FIFO_DEPTH) - 13'(count_s) - 13'(inflight_r);
    take_tgt_s    = (state_r == IDLE) && target_valid && !flush && (free_s >= beats_tgt_s);
    take_pf_s     = (state_r == IDLE) && !target_valid && pf_armed_r && !flush &&
                    (free_s >= beats_pf_s);
    issue_addr_s  = take_tgt_s ? tgt_addr_s : next_pc_r;
    issue_beats_s = take_tgt_s ? beats_tgt_s : beats_pf_s;
    beat_s        = r_valid && r_ready_r;
    enq_valid_s   = beat_s && (state_r == DATA);
    enq_entry_s.data = r_data;
    enq_entry_s.pc   = pc_r;
`ifdef INTIRVX_IFETCH_ERR_EN
    enq_entry_s.err  = beat_err_s;
`endif
  end

  // Fetch state machine; AR attributes are held in registers until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ar_valid_r   <= 1'b0;
      ar_addr_r    <= {ALEN{1'b0}};
      ar_len_r     <= 8'd0;
      ar_id_r      <= {ILEN{1'b0}};
      r_ready_r    <= 1'b0;
      inflight_r   <= {IW{1'b0}};
      pc_r         <= {ALEN{1'b0}};
      next_pc_r    <= {ALEN{1'b0}};
      pf_armed_r   <= 1'b0;
      flush_seen_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          flush_seen_r <= 1'b0;
          if (take_tgt_s || take_pf_s) begin
            ar_addr_r  <= issue_addr_s;
            ar_len_r   <= 8'(issue_beats_s - 13'd1);
            ar_id_r    <= hart_id;
            ar_valid_r <= 1'b1;
            pf_armed_r <= 1'b0;
            state_r    <= ADDR;
          end else if (flush) begin
            pf_armed_r <= 1'b0;
          end
        end
        ADDR: begin
          if (ar_ready) begin
            ar_valid_r <= 1'b0;
            inflight_r <= IW'({1'b0, ar_len_r} + 9'd1);
            pc_r       <= ar_addr_r;
            r_ready_r  <= 1'b1;
            state_r    <= (flush_seen_r || flush) ? DRAIN : DATA;
          end else if (flush) begin
            flush_seen_r <= 1'b1;
          end
        end
        DATA: begin
          if (beat_s) begin
            pc_r       <= pc_r + IFETCH_INCR;
            inflight_r <= inflight_r - IW'(1);
            if (r_last) begin
              next_pc_r  <= pc_r + IFETCH_INCR;
              pf_armed_r <= (SEQ_PREFETCH != 0) && !flush && !beat_err_s;
              inflight_r <= {IW{1'b0}};
              r_ready_r  <= 1'b0;
              state_r    <= IDLE;
            end else if (flush || beat_err_s) begin
              state_r <= DRAIN;
            end
          end else if (flush) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (beat_s) begin
            inflight_r <= inflight_r - IW'(1);
            if (r_last) begin
              inflight_r <= {IW{1'b0}};
              pf_armed_r <= 1'b0;
              r_ready_r  <= 1'b0;
              state_r    <= IDLE;
            end
          end
        end
        default: begin
          ar_valid_r <= 1'b0;
          r_ready_r  <= 1'b0;
          inflight_r <= {IW{1'b0}};
          pf_armed_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  intirvx_ifetch_buf #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW),
    .EW    (EW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq_valid (enq_valid_s),
    .enq_ready (enq_ready_unused_s),
    .enq_data  (enq_entry_s),
    .deq_valid (inst_valid),
    .deq_ready (inst_ready),
    .deq_data  (head_bits_s),
    .count     (count_s)
  );

  assign head_s       = ifetch_entry_t'(head_bits_s);
  assign inst         = head_s.data;
  assign inst_pc      = head_s.pc;
`ifdef INTIRVX_IFETCH_ERR_EN
  assign inst_err     = head_s.err;
`endif
  assign target_ready = take_tgt_s;
  assign ar_valid     = ar_valid_r;
  assign ar_addr      = ar_addr_r;
  assign ar_len       = ar_len_r;
  assign ar_id        = ar_id_r;
  assign ar_size      = AXI_SIZE_S32;
  assign ar_burst     = AXI_BURST_INCR;
  assign ar_prot      = AXI_PROT_NONE;
  assign r_ready      = r_ready_r;
  assign aw_valid     = 1'b0;
  assign w_valid      = 1'b0;
  assign b_ready      = 1'b0;

endmodule

// File: tb/tb_intirvx_ifetch_pf.sv
// Directed bench for intirvx_ifetch_pf driving the AXI read slave by hand.
// Define INTIRVX_IFETCH_ERR_EN for RTL and bench together to cover the error path.
module tb_intirvx_ifetch_pf;
  import intirvx_ifetch_pf_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ILEN-1:0] hart_id;
  logic            ar_valid, ar_ready;
  logic [ALEN-1:0] ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size, ar_prot;
  logic [1:0]      ar_burst;
  logic [ILEN-1:0] ar_id;
  logic            r_valid, r_ready, r_last;
  logic [XLEN-1:0] r_data;
  logic [1:0]      r_resp;
  logic            aw_valid, w_valid, b_ready;
  logic [XLEN-1:0] inst;
  logic [ALEN-1:0] inst_pc;
  logic            inst_valid, inst_ready;
`ifdef INTIRVX_IFETCH_ERR_EN
  logic            inst_err;
`endif
  logic [XLEN-1:0] target;
  logic            target_valid, target_ready, flush;

  int n_assert = 0;
  int n_fail   = 0;

  intirvx_ifetch_pf #(.BURST_LEN(8), .FIFO_DEPTH(16), .SEQ_PREFETCH(1)) dut (
    .clk(clk), .rst_n(rst_n), .hart_id(hart_id),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_prot(ar_prot), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .aw_valid(aw_valid), .w_valid(w_valid), .b_ready(b_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
`ifdef INTIRVX_IFETCH_ERR_EN
    .inst_err(inst_err),
`endif
    .target(target), .target_valid(target_valid), .target_ready(target_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic wait_ar(input logic [31:0] addr, input logic [7:0] len, input string tag);
    int n = 0;
    while (ar_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_ar_valid"}, 64'(ar_valid), 64'h1);
    chk({tag, "_ar_addr"}, 64'(ar_addr), 64'(addr));
    chk({tag, "_ar_len"}, 64'(ar_len), 64'(len));
  endtask

  task automatic ar_hs;
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    chk("ar_valid_drop", 64'(ar_valid), 64'h0);
  endtask

  task automatic send(input logic [31:0] base, input int first, input int cnt,
                      input int total, input int err_idx, input string tag);
    for (int i = first; i < first + cnt; i++) begin
      r_valid = 1'b1;
      r_data  = mem_word(base + 32'(i * 4));
      r_last  = (i == total - 1);
      r_resp  = (i == err_idx) ? 2'b10 : 2'b00;
      chk({tag, "_r_ready"}, 64'(r_ready), 64'h1);
      tick();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
  endtask

  task automatic pop(input logic [31:0] pc, input logic err, input string tag);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(inst_valid), 64'h1);
    chk({tag, "_pc"}, 64'(inst_pc), 64'(pc));
    chk({tag, "_data"}, 64'(inst), 64'(mem_word(pc)));
`ifdef INTIRVX_IFETCH_ERR_EN
    chk({tag, "_err"}, 64'(inst_err), 64'(err));
`else
    if (err) begin
      $display("note: error flag not built in");
    end
`endif
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic quiet(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk({tag, "_no_ar"}, 64'(ar_valid), 64'h0);
      chk({tag, "_no_inst"}, 64'(inst_valid), 64'h0);
    end
  endtask

  task automatic redirect(input logic [31:0] t, input string tag);
    target       = t;
    target_valid = 1'b1;
    #1;
    chk({tag, "_tready"}, 64'(target_ready), 64'h1);
    tick();
    target_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hart_id = 4'h3; ar_ready = 1'b0; r_valid = 1'b0; r_data = 32'h0;
    r_resp = 2'b00; r_last = 1'b0; inst_ready = 1'b0; target = 32'h0;
    target_valid = 1'b0; flush = 1'b0;
    repeat (3) tick();
    chk("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk("rst_target_ready", 64'(target_ready), 64'h0);
    chk("rst_ar_valid", 64'(ar_valid), 64'h0);
    chk("rst_r_ready", 64'(r_ready), 64'h0);
    chk("rst_aw_w_b", 64'({aw_valid, w_valid, b_ready}), 64'h0);
    rst_n = 1'b1;
    tick();

    // Basic fetch with a misaligned redirect forced down to 0x1000.
    redirect(32'h0000_1003, "basic");
    wait_ar(32'h1000, 8'd7, "basic");
    chk("basic_ar_size", 64'(ar_size), 64'h2);
    chk("basic_ar_burst", 64'(ar_burst), 64'h1);
    chk("basic_ar_prot", 64'(ar_prot), 64'h0);
    chk("basic_ar_id", 64'(ar_id), 64'h3);
    ar_hs();
    send(32'h1000, 0, 8, 8, -1, "basic");
    for (int i = 0; i < 8; i++) pop(32'h1000 + 32'(i * 4), 1'b0, "basic_pop");
    wait_ar(32'h1020, 8'd7, "pf1");

    // Flush while the prefetch AR waits: address phase stays put, data is drained.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("fa_ar_valid_hold", 64'(ar_valid), 64'h1);
      chk("fa_ar_addr_hold", 64'(ar_addr), 64'h1020);
      tick();
    end
    ar_hs();
    send(32'h1020, 0, 8, 8, -1, "fa_drain");
    quiet(4, "fa");

    // Page-boundary truncation, then prefetch at the next page.
    redirect(32'h0000_1FF8, "page");
    wait_ar(32'h1FF8, 8'd1, "page");
    ar_hs();
    send(32'h1FF8, 0, 2, 2, -1, "page");
    pop(32'h1FF8, 1'b0, "page_pop0");
    pop(32'h1FFC, 1'b0, "page_pop1");
    wait_ar(32'h2000, 8'd7, "page_pf");

    // Back-pressure: two bursts fill the buffer, a third waits for eight free slots.
    ar_hs();
    send(32'h2000, 0, 8, 8, -1, "bp1");
    wait_ar(32'h2020, 8'd7, "bp2");
    ar_hs();
    send(32'h2020, 0, 8, 8, -1, "bp2");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_full_no_ar", 64'(ar_valid), 64'h0);
      chk("bp_hold_pc", 64'(inst_pc), 64'h2000);
    end
    pop(32'h2000, 1'b0, "bp_pop_first");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_one_free_no_ar", 64'(ar_valid), 64'h0);
    end
    for (int i = 1; i < 8; i++) pop(32'h2000 + 32'(i * 4), 1'b0, "bp_pop");
    wait_ar(32'h2040, 8'd7, "bp3");
    ar_hs();

    // Flush after beat 3 of 8: buffer empties, remaining beats are swallowed.
    send(32'h2040, 0, 3, 8, -1, "fm_head");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fm_valid_cleared", 64'(inst_valid), 64'h0);
    send(32'h2040, 3, 5, 8, -1, "fm_tail");
    quiet(4, "fm");
    redirect(32'h0000_4000, "restart");
    wait_ar(32'h4000, 8'd7, "restart");
    ar_hs();
    send(32'h4000, 0, 8, 8, -1, "restart");
    pop(32'h4000, 1'b0, "restart_pop0");
    pop(32'h4004, 1'b0, "restart_pop1");
    wait_ar(32'h4020, 8'd7, "restart_pf");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ar_hs();
    send(32'h4020, 0, 8, 8, -1, "restart_drain");
    quiet(3, "restart");

`ifdef INTIRVX_IFETCH_ERR_EN
    // Error response on beat 2 stops fetching after flagging that word.
    redirect(32'h0000_5000, "err");
    wait_ar(32'h5000, 8'd7, "err");
    ar_hs();
    send(32'h5000, 0, 8, 8, 1, "err");
    pop(32'h5000, 1'b0, "err_pop0");
    pop(32'h5004, 1'b1, "err_pop1");
    quiet(5, "err");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
